// File: rtl/maincontrol_if.sv
// Control bundle between the multicycle main controller and the datapath/alucontrol.
// The controller side uses the master modport; the datapath side uses slave.
interface maincontrol_if #(
   parameter int RETW = 32
);
   logic [5:0]      op;
   logic            zero;
   logic            memready;
   logic            memread;
   logic            memwrite;
   logic            irwrite;
   logic            iord;
   logic            alusrca;
   logic [1:0]      alusrcb;
   logic [1:0]      aluop;
   logic [1:0]      pcsource;
   logic            pcen;
   logic            regwrite;
   logic            regdst;
   logic            memtoreg;
   logic            illegal;
   logic [3:0]      state;
   logic [RETW-1:0] instret;

   modport master (
      input  op, zero, memready,
      output memread, memwrite, irwrite, iord, alusrca, alusrcb, aluop,
             pcsource, pcen, regwrite, regdst, memtoreg, illegal, state, instret
   );

   modport slave (
      output op, zero, memready,
      input  memread, memwrite, irwrite, iord, alusrca, alusrcb, aluop,
             pcsource, pcen, regwrite, regdst, memtoreg, illegal, state, instret
   );
endinterface

// File: rtl/maincontrol.sv
// Multicycle MIPS main controller: fetch/decode/execute/memory/writeback sequencing,
// memready-stalled memory accesses and a retired-instruction counter.
module maincontrol #(
   parameter int RETW = 32
) (
   input  logic          clk,
   input  logic          reset,
   maincontrol_if.master bus
);
   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      JEX     = 4'd9,
      ADDIEX  = 4'd10,
      ADDIWB  = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_t          state_q, state_d;
   logic [RETW-1:0] instret_q;
   logic            retire;
   logic            memread_c, memwrite_c, irwrite_c, pcen_c, regwrite_c, illegal_c;
   logic            iord_c, alusrca_c, regdst_c, memtoreg_c;
   logic [1:0]      alusrcb_c, aluop_c, pcsource_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire)
            instret_q <= instret_q + RETW'(1);
      end
   end

   always_comb begin
      state_d    = FETCH;
      retire     = 1'b0;
      memread_c  = 1'b0;
      memwrite_c = 1'b0;
      irwrite_c  = 1'b0;
      pcen_c     = 1'b0;
      regwrite_c = 1'b0;
      illegal_c  = 1'b0;
      iord_c     = 1'b0;
      alusrca_c  = 1'b0;
      regdst_c   = 1'b0;
      memtoreg_c = 1'b0;
      alusrcb_c  = 2'b00;
      aluop_c    = 2'b00;
      pcsource_c = 2'b00;
      case (state_q)
         FETCH: begin
            memread_c = 1'b1;
            alusrcb_c = 2'b01;
            irwrite_c = bus.memready;
            pcen_c    = bus.memready;
            state_d   = bus.memready ? DECODE : FETCH;
         end
         DECODE: begin
            alusrcb_c = 2'b11;
            case (bus.op)
               OP_LB, OP_SB: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_J:         state_d = JEX;
               OP_ADDI:      state_d = ADDIEX;
               default: begin
                  state_d   = FETCH;
                  illegal_c = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alusrca_c = 1'b1;
            alusrcb_c = 2'b10;
            if (bus.op == OP_LB)
               state_d = MEMRD;
            else if (bus.op == OP_SB)
               state_d = MEMWR;
         end
         MEMRD: begin
            memread_c = 1'b1;
            iord_c    = 1'b1;
            state_d   = bus.memready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            regwrite_c = 1'b1;
            memtoreg_c = 1'b1;
            retire     = 1'b1;
         end
         MEMWR: begin
            memwrite_c = 1'b1;
            iord_c     = 1'b1;
            state_d    = bus.memready ? FETCH : MEMWR;
            retire     = bus.memready;
         end
         RTYPEEX: begin
            alusrca_c = 1'b1;
            aluop_c   = 2'b10;
            state_d   = RTYPEWB;
         end
         RTYPEWB: begin
            regwrite_c = 1'b1;
            regdst_c   = 1'b1;
            retire     = 1'b1;
         end
         BEQEX: begin
            alusrca_c  = 1'b1;
            aluop_c    = 2'b01;
            pcsource_c = 2'b01;
            pcen_c     = bus.zero;
            retire     = 1'b1;
         end
         JEX: begin
            pcsource_c = 2'b10;
            pcen_c     = 1'b1;
            retire     = 1'b1;
         end
         ADDIEX: begin
            alusrca_c = 1'b1;
            alusrcb_c = 2'b10;
            state_d   = ADDIWB;
         end
         ADDIWB: begin
            regwrite_c = 1'b1;
            retire     = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

   // Strobes are gated by reset so an aborted memory access releases immediately.
   assign bus.memread  = memread_c  & ~reset;
   assign bus.memwrite = memwrite_c & ~reset;
   assign bus.irwrite  = irwrite_c  & ~reset;
   assign bus.pcen     = pcen_c     & ~reset;
   assign bus.regwrite = regwrite_c & ~reset;
   assign bus.illegal  = illegal_c  & ~reset;
   assign bus.iord     = iord_c;
   assign bus.alusrca  = alusrca_c;
   assign bus.alusrcb  = alusrcb_c;
   assign bus.aluop    = aluop_c;
   assign bus.pcsource = pcsource_c;
   assign bus.regdst   = regdst_c;
   assign bus.memtoreg = memtoreg_c;
   assign bus.state    = state_q;
   assign bus.instret  = instret_q;
endmodule

// File: tb/tb_maincontrol.sv
// Bench for maincontrol: directed scenarios plus a randomized instruction stream
// checked against an instruction-level model of expected state sequences and retirement.
module tb_maincontrol;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LB   = 6'b100000;
   localparam logic [5:0] OP_SB   = 6'b101000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   maincontrol_if #(.RETW(32)) bus ();
   maincontrol #(.RETW(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic [3:0]  st;
      logic        mr;
      logic        mrd, mwr, irw, iord, srca, pcen, regw, regdst, m2r, ill;
      logic [1:0]  srcb, aluop, pcsrc;
      logic [31:0] instret;
   } obs_t;

   obs_t        obs[$];
   int          exp_st[$];
   bit          exp_legal;
   logic [31:0] exp_instret;
   int          n_cmp = 0;
   int          n_fail = 0;

   // Expected state walk is derived from the instruction class and its wait counts.
   task automatic run_instr(input logic [5:0] o, input logic z, input int fw, input int mw);
      int   mr_plan[$];
      obs_t s;
      obs.delete();
      exp_st.delete();
      for (int k = 0; k < fw; k++) begin exp_st.push_back(0); mr_plan.push_back(0); end
      exp_st.push_back(0); mr_plan.push_back(1);
      exp_st.push_back(1); mr_plan.push_back(int'($urandom_range(0, 1)));
      exp_legal = 1'b1;
      case (o)
         OP_LB: begin
            exp_st.push_back(2); mr_plan.push_back(int'($urandom_range(0, 1)));
            for (int k = 0; k < mw; k++) begin exp_st.push_back(3); mr_plan.push_back(0); end
            exp_st.push_back(3); mr_plan.push_back(1);
            exp_st.push_back(4); mr_plan.push_back(int'($urandom_range(0, 1)));
         end
         OP_SB: begin
            exp_st.push_back(2); mr_plan.push_back(int'($urandom_range(0, 1)));
            for (int k = 0; k < mw; k++) begin exp_st.push_back(5); mr_plan.push_back(0); end
            exp_st.push_back(5); mr_plan.push_back(1);
         end
         OP_R: begin
            exp_st.push_back(6); mr_plan.push_back(0);
            exp_st.push_back(7); mr_plan.push_back(1);
         end
         OP_BEQ: begin exp_st.push_back(8); mr_plan.push_back(int'($urandom_range(0, 1))); end
         OP_J:   begin exp_st.push_back(9); mr_plan.push_back(int'($urandom_range(0, 1))); end
         OP_ADDI: begin
            exp_st.push_back(10); mr_plan.push_back(1);
            exp_st.push_back(11); mr_plan.push_back(0);
         end
         default: exp_legal = 1'b0;
      endcase
      bus.op   = o;
      bus.zero = z;
      for (int k = 0; k < exp_st.size(); k++) begin
         bus.memready = (mr_plan[k] != 0);
         #1;
         s.st = bus.state;     s.mr = bus.memready;
         s.mrd = bus.memread;  s.mwr = bus.memwrite;  s.irw = bus.irwrite;
         s.iord = bus.iord;    s.srca = bus.alusrca;  s.pcen = bus.pcen;
         s.regw = bus.regwrite; s.regdst = bus.regdst; s.m2r = bus.memtoreg;
         s.ill = bus.illegal;  s.srcb = bus.alusrcb;  s.aluop = bus.aluop;
         s.pcsrc = bus.pcsource; s.instret = bus.instret;
         obs.push_back(s);
         @(posedge clk);
         @(negedge clk);
      end
      if (exp_legal) exp_instret = exp_instret + 32'd1;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.memready = 1'b1; bus.op = OP_R; bus.zero = 1'b0;
      exp_instret = 32'd0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (bus.state !== 4'd0) begin n_fail++; $display("FAIL reset_state got=%0d want=0", bus.state); end
         n_cmp++;
         if (bus.instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret got=%0d want=0", bus.instret); end
         n_cmp++;
         if ({bus.memread, bus.memwrite, bus.irwrite, bus.pcen, bus.regwrite, bus.illegal} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes got=%b want=000000",
               {bus.memread, bus.memwrite, bus.irwrite, bus.pcen, bus.regwrite, bus.illegal});
         end
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({bus.irwrite, bus.pcen, bus.memread} !== 3'b111) begin
         n_fail++; $display("FAIL first_fetch irwrite/pcen/memread got=%b want=111",
            {bus.irwrite, bus.pcen, bus.memread});
      end
   endtask

   task automatic test_rtype_addi();
      logic [31:0] start = exp_instret;
      run_instr(OP_R, 1'b0, 0, 0);
      n_cmp++;
      if (obs.size() !== 4 || obs[0].st !== 4'd0 || obs[1].st !== 4'd1 || obs[2].st !== 4'd6 || obs[3].st !== 4'd7) begin
         n_fail++; $display("FAIL rtype_seq got=%0d,%0d,%0d,%0d want=0,1,6,7", obs[0].st, obs[1].st, obs[2].st, obs[3].st);
      end
      n_cmp++;
      if (obs[2].aluop !== 2'b10) begin n_fail++; $display("FAIL rtype_aluop got=%b want=10", obs[2].aluop); end
      n_cmp++;
      if (obs[3].regdst !== 1'b1 || obs[3].regw !== 1'b1) begin
         n_fail++; $display("FAIL rtype_wb regdst/regwrite got=%b%b want=11", obs[3].regdst, obs[3].regw);
      end
      run_instr(OP_ADDI, 1'b0, 0, 0);
      n_cmp++;
      if (obs[0].st !== 4'd0 || obs[1].st !== 4'd1 || obs[2].st !== 4'd10 || obs[3].st !== 4'd11) begin
         n_fail++; $display("FAIL addi_seq got=%0d,%0d,%0d,%0d want=0,1,10,11", obs[0].st, obs[1].st, obs[2].st, obs[3].st);
      end
      n_cmp++;
      if (obs[2].srcb !== 2'b10 || obs[2].srca !== 1'b1) begin
         n_fail++; $display("FAIL addi_ex srca/srcb got=%b/%b want=1/10", obs[2].srca, obs[2].srcb);
      end
      #1;
      n_cmp++;
      if (bus.instret !== start + 32'd2) begin n_fail++; $display("FAIL rtype_addi_instret got=%0d want=%0d", bus.instret, start + 32'd2); end
   endtask

   task automatic test_lb_wait();
      int n_rd = 0;
      run_instr(OP_LB, 1'b0, 0, 2);
      for (int k = 0; k < obs.size(); k++) begin
         n_cmp++;
         if (obs[k].st !== 4'(exp_st[k])) begin n_fail++; $display("FAIL lb_state[%0d] got=%0d want=%0d", k, obs[k].st, exp_st[k]); end
         if (obs[k].st == 4'd3) begin
            n_rd++;
            n_cmp++;
            if (obs[k].mrd !== 1'b1 || obs[k].iord !== 1'b1) begin
               n_fail++; $display("FAIL lb_memrd[%0d] memread/iord got=%b%b want=11", k, obs[k].mrd, obs[k].iord);
            end
         end
      end
      n_cmp++;
      if (n_rd !== 3) begin n_fail++; $display("FAIL lb_memrd_cycles got=%0d want=3", n_rd); end
      n_cmp++;
      if (obs[6].m2r !== 1'b1 || obs[6].regw !== 1'b1) begin
         n_fail++; $display("FAIL lb_memwb memtoreg/regwrite got=%b%b want=11", obs[6].m2r, obs[6].regw);
      end
      #1;
      n_cmp++;
      if (bus.state !== 4'd0) begin n_fail++; $display("FAIL lb_total_cycles state_after_7=%0d want=0", bus.state); end
   endtask

   task automatic test_beq();
      for (int zi = 1; zi >= 0; zi--) begin
         run_instr(OP_BEQ, zi[0], 0, 0);
         n_cmp++;
         if (obs[2].st !== 4'd8) begin n_fail++; $display("FAIL beq_state got=%0d want=8", obs[2].st); end
         n_cmp++;
         if (obs[2].aluop !== 2'b01 || obs[2].pcsrc !== 2'b01) begin
            n_fail++; $display("FAIL beq_ctrl aluop/pcsource got=%b/%b want=01/01", obs[2].aluop, obs[2].pcsrc);
         end
         n_cmp++;
         if (obs[2].pcen !== zi[0]) begin n_fail++; $display("FAIL beq_pcen zero=%0d got=%b want=%b", zi, obs[2].pcen, zi[0]); end
         #1;
         n_cmp++;
         if (bus.instret !== exp_instret) begin n_fail++; $display("FAIL beq_retire got=%0d want=%0d", bus.instret, exp_instret); end
      end
   endtask

   task automatic test_illegal_j();
      run_instr(6'b111111, 1'b0, 0, 0);
      n_cmp++;
      if (obs.size() !== 2 || obs[1].st !== 4'd1 || obs[1].ill !== 1'b1 || obs[0].ill !== 1'b0) begin
         n_fail++; $display("FAIL illegal_pulse state=%0d illegal=%b,%b want=1 0,1", obs[1].st, obs[0].ill, obs[1].ill);
      end
      #1;
      n_cmp++;
      if (bus.state !== 4'd0 || bus.illegal !== 1'b0) begin
         n_fail++; $display("FAIL illegal_return state=%0d illegal=%b want=0 0", bus.state, bus.illegal);
      end
      n_cmp++;
      if (bus.instret !== exp_instret) begin n_fail++; $display("FAIL illegal_instret got=%0d want=%0d", bus.instret, exp_instret); end
      run_instr(OP_J, 1'b0, 0, 0);
      n_cmp++;
      if (obs[2].st !== 4'd9 || obs[2].pcsrc !== 2'b10 || obs[2].pcen !== 1'b1) begin
         n_fail++; $display("FAIL j_ex state/pcsource/pcen got=%0d/%b/%b want=9/10/1", obs[2].st, obs[2].pcsrc, obs[2].pcen);
      end
      #1;
      n_cmp++;
      if (bus.instret !== exp_instret) begin n_fail++; $display("FAIL j_instret got=%0d want=%0d", bus.instret, exp_instret); end
   endtask

   task automatic test_sb_reset();
      bus.op = OP_SB; bus.memready = 1'b1;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      bus.memready = 1'b0;
      #1;
      n_cmp++;
      if (bus.state !== 4'd5 || bus.memwrite !== 1'b1) begin
         n_fail++; $display("FAIL sb_wait state/memwrite got=%0d/%b want=5/1", bus.state, bus.memwrite);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.memwrite !== 1'b0) begin n_fail++; $display("FAIL sb_reset_memwrite got=%b want=0", bus.memwrite); end
      @(posedge clk); @(negedge clk);
      reset = 1'b0; bus.memready = 1'b1;
      #1;
      n_cmp++;
      if (bus.state !== 4'd0) begin n_fail++; $display("FAIL sb_reset_state got=%0d want=0", bus.state); end
      n_cmp++;
      if (bus.instret !== 32'd0) begin n_fail++; $display("FAIL sb_reset_instret got=%0d want=0", bus.instret); end
      exp_instret = 32'd0;
   endtask

   task automatic test_random();
      logic [5:0] ops [8] = '{OP_R, OP_LB, OP_SB, OP_BEQ, OP_J, OP_ADDI, 6'b100011, 6'b111111};
      logic [5:0] o;
      logic       z;
      logic       e_rd, e_wr, e_irw, e_iord, e_pcen, e_regw, e_ill;
      for (int n = 0; n < 60; n++) begin
         o = ops[$urandom_range(0, 7)];
         z = 1'($urandom_range(0, 1));
         run_instr(o, z, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
         n_cmp++;
         if (obs[0].instret !== exp_instret - (exp_legal ? 32'd1 : 32'd0)) begin
            n_fail++; $display("FAIL rnd_instret[%0d] got=%0d", n, obs[0].instret);
         end
         for (int k = 0; k < obs.size(); k++) begin
            n_cmp++;
            if (obs[k].st !== 4'(exp_st[k])) begin
               n_fail++; $display("FAIL rnd_state[%0d.%0d] op=%b got=%0d want=%0d", n, k, o, obs[k].st, exp_st[k]);
            end
            e_rd   = (exp_st[k] == 0) || (exp_st[k] == 3);
            e_wr   = (exp_st[k] == 5);
            e_irw  = (exp_st[k] == 0) && obs[k].mr;
            e_iord = (exp_st[k] == 3) || (exp_st[k] == 5);
            e_pcen = ((exp_st[k] == 0) && obs[k].mr) || ((exp_st[k] == 8) && z) || (exp_st[k] == 9);
            e_regw = (exp_st[k] == 4) || (exp_st[k] == 7) || (exp_st[k] == 11);
            e_ill  = (exp_st[k] == 1) && !exp_legal;
            n_cmp++;
            if ({obs[k].mrd, obs[k].mwr, obs[k].irw, obs[k].iord, obs[k].pcen, obs[k].regw, obs[k].ill}
                !== {e_rd, e_wr, e_irw, e_iord, e_pcen, e_regw, e_ill}) begin
               n_fail++; $display("FAIL rnd_strobes[%0d.%0d] st=%0d got=%b want=%b", n, k, exp_st[k],
                  {obs[k].mrd, obs[k].mwr, obs[k].irw, obs[k].iord, obs[k].pcen, obs[k].regw, obs[k].ill},
                  {e_rd, e_wr, e_irw, e_iord, e_pcen, e_regw, e_ill});
            end
         end
      end
      #1;
      n_cmp++;
      if (bus.instret !== exp_instret) begin n_fail++; $display("FAIL rnd_final_instret got=%0d want=%0d", bus.instret, exp_instret); end
   endtask

   initial begin
      test_reset();
      test_rtype_addi();
      test_lb_wait();
      test_beq();
      test_illegal_j();
      test_sb_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
